// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage buffered in a DEPTH-entry circular FIFO.
// Define DECODE_QUEUE_BYPASS_EN for zero-latency issue into an empty queue.
module decode_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int ROBBW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_prd_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [31:0]       out_imm,
  output logic [5:0]        out_code,
  output logic [2:0]        out_type,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_prd_pc,
  output logic              out_illegal,
  output logic [ADDR_W:0]   count
);

  localparam logic [2:0] TY_ALU = 3'd1;
  localparam logic [2:0] TY_LD  = 3'd2;
  localparam logic [2:0] TY_ST  = 3'd3;
  localparam logic [2:0] TY_BRC = 3'd4;
  localparam logic [2:0] TY_JMP = 3'd5;

  localparam logic [5:0] C_LUI   = 6'd1;
  localparam logic [5:0] C_AUIPC = 6'd2;
  localparam logic [5:0] C_JAL   = 6'd3;
  localparam logic [5:0] C_JALR  = 6'd4;
  localparam logic [5:0] C_BEQ   = 6'd5;
  localparam logic [5:0] C_BNE   = 6'd6;
  localparam logic [5:0] C_BLT   = 6'd7;
  localparam logic [5:0] C_BGE   = 6'd8;
  localparam logic [5:0] C_BLTU  = 6'd9;
  localparam logic [5:0] C_BGEU  = 6'd10;
  localparam logic [5:0] C_LB    = 6'd11;
  localparam logic [5:0] C_LH    = 6'd12;
  localparam logic [5:0] C_LW    = 6'd13;
  localparam logic [5:0] C_LBU   = 6'd14;
  localparam logic [5:0] C_LHU   = 6'd15;
  localparam logic [5:0] C_SB    = 6'd16;
  localparam logic [5:0] C_SH    = 6'd17;
  localparam logic [5:0] C_SW    = 6'd18;
  localparam logic [5:0] C_ADDI  = 6'd19;
  localparam logic [5:0] C_SLTI  = 6'd20;
  localparam logic [5:0] C_SLTIU = 6'd21;
  localparam logic [5:0] C_XORI  = 6'd22;
  localparam logic [5:0] C_ORI   = 6'd23;
  localparam logic [5:0] C_ANDI  = 6'd24;
  localparam logic [5:0] C_SLLI  = 6'd25;
  localparam logic [5:0] C_SRLI  = 6'd26;
  localparam logic [5:0] C_SRAI  = 6'd27;
  localparam logic [5:0] C_ADD   = 6'd28;
  localparam logic [5:0] C_SUB   = 6'd29;
  localparam logic [5:0] C_SLL   = 6'd30;
  localparam logic [5:0] C_SLT   = 6'd31;
  localparam logic [5:0] C_SLTU  = 6'd32;
  localparam logic [5:0] C_XOR   = 6'd33;
  localparam logic [5:0] C_SRL   = 6'd34;
  localparam logic [5:0] C_SRA   = 6'd35;
  localparam logic [5:0] C_OR    = 6'd36;
  localparam logic [5:0] C_AND   = 6'd37;

  localparam logic [ADDR_W:0]   LP_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_CONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PONE = ADDR_W'(1);

  if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || ROBBW < 1) begin : g_bad_params
  end

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [5:0]  code;
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [31:0] prd_pc;
    logic        ill;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;

  entry_t      w_dec;
  entry_t      w_out;
  logic        w_ok;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_shamt;
  logic        w_op_lui;
  logic        w_op_auipc;
  logic        w_op_jal;
  logic        w_op_jalr;
  logic        w_op_br;
  logic        w_op_ld;
  logic        w_op_st;
  logic        w_op_opi;
  logic        w_op_opr;
  logic        w_full;
  logic        w_empty;
  logic        w_byp;
  logic        w_enq;
  logic        w_deq;

  assign w_op  = in_inst[6:0];
  assign w_f3  = in_inst[14:12];
  assign w_f7  = in_inst[31:25];
  assign w_rd  = in_inst[11:7];
  assign w_rs1 = in_inst[19:15];
  assign w_rs2 = in_inst[24:20];

  assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                    in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u = {in_inst[31:12], 12'b0};
  assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};
  assign w_shamt = {27'b0, in_inst[24:20]};

  assign w_op_lui   = (w_op == 7'b0110111);
  assign w_op_auipc = (w_op == 7'b0010111);
  assign w_op_jal   = (w_op == 7'b1101111);
  assign w_op_jalr  = (w_op == 7'b1100111);
  assign w_op_br    = (w_op == 7'b1100011);
  assign w_op_ld    = (w_op == 7'b0000011);
  assign w_op_st    = (w_op == 7'b0100011);
  assign w_op_opi   = (w_op == 7'b0010011);
  assign w_op_opr   = (w_op == 7'b0110011);

  always_comb begin
    w_dec        = '0;
    w_dec.pc     = in_pc;
    w_dec.prd_pc = in_prd_pc;
    w_ok         = 1'b1;
    unique case (1'b1)
      w_op_lui: begin
        w_dec.code = C_LUI;
        w_dec.typ  = TY_ALU;
        w_dec.rd   = w_rd;
        w_dec.imm  = w_imm_u;
      end
      w_op_auipc: begin
        w_dec.code = C_AUIPC;
        w_dec.typ  = TY_ALU;
        w_dec.rd   = w_rd;
        w_dec.imm  = w_imm_u;
      end
      w_op_jal: begin
        w_dec.code = C_JAL;
        w_dec.typ  = TY_JMP;
        w_dec.rd   = w_rd;
        w_dec.imm  = w_imm_j;
      end
      w_op_jalr: begin
        w_ok       = (w_f3 == 3'b000);
        w_dec.code = C_JALR;
        w_dec.typ  = TY_JMP;
        w_dec.rd   = w_rd;
        w_dec.rs1  = w_rs1;
        w_dec.imm  = w_imm_i;
      end
      w_op_br: begin
        w_dec.typ = TY_BRC;
        w_dec.rs1 = w_rs1;
        w_dec.rs2 = w_rs2;
        w_dec.imm = w_imm_b;
        case (w_f3)
          3'b000:  w_dec.code = C_BEQ;
          3'b001:  w_dec.code = C_BNE;
          3'b100:  w_dec.code = C_BLT;
          3'b101:  w_dec.code = C_BGE;
          3'b110:  w_dec.code = C_BLTU;
          3'b111:  w_dec.code = C_BGEU;
          default: w_ok = 1'b0;
        endcase
      end
      w_op_ld: begin
        w_dec.typ = TY_LD;
        w_dec.rd  = w_rd;
        w_dec.rs1 = w_rs1;
        w_dec.imm = w_imm_i;
        case (w_f3)
          3'b000:  w_dec.code = C_LB;
          3'b001:  w_dec.code = C_LH;
          3'b010:  w_dec.code = C_LW;
          3'b100:  w_dec.code = C_LBU;
          3'b101:  w_dec.code = C_LHU;
          default: w_ok = 1'b0;
        endcase
      end
      w_op_st: begin
        w_dec.typ = TY_ST;
        w_dec.rs1 = w_rs1;
        w_dec.rs2 = w_rs2;
        w_dec.imm = w_imm_s;
        case (w_f3)
          3'b000:  w_dec.code = C_SB;
          3'b001:  w_dec.code = C_SH;
          3'b010:  w_dec.code = C_SW;
          default: w_ok = 1'b0;
        endcase
      end
      w_op_opi: begin
        w_dec.typ = TY_ALU;
        w_dec.rd  = w_rd;
        w_dec.rs1 = w_rs1;
        w_dec.imm = w_imm_i;
        case (w_f3)
          3'b000: w_dec.code = C_ADDI;
          3'b010: w_dec.code = C_SLTI;
          3'b011: w_dec.code = C_SLTIU;
          3'b100: w_dec.code = C_XORI;
          3'b110: w_dec.code = C_ORI;
          3'b111: w_dec.code = C_ANDI;
          3'b001: begin
            w_ok       = (w_f7 == 7'h00);
            w_dec.code = C_SLLI;
            w_dec.imm  = w_shamt;
          end
          default: begin
            w_ok       = (w_f7 == 7'h00) || (w_f7 == 7'h20);
            w_dec.code = w_f7[5] ? C_SRAI : C_SRLI;
            w_dec.imm  = w_shamt;
          end
        endcase
      end
      w_op_opr: begin
        w_dec.typ = TY_ALU;
        w_dec.rd  = w_rd;
        w_dec.rs1 = w_rs1;
        w_dec.rs2 = w_rs2;
        if (w_f7 == 7'h00) begin
          case (w_f3)
            3'b000:  w_dec.code = C_ADD;
            3'b001:  w_dec.code = C_SLL;
            3'b010:  w_dec.code = C_SLT;
            3'b011:  w_dec.code = C_SLTU;
            3'b100:  w_dec.code = C_XOR;
            3'b101:  w_dec.code = C_SRL;
            3'b110:  w_dec.code = C_OR;
            default: w_dec.code = C_AND;
          endcase
        end else if (w_f7 == 7'h20 && w_f3 == 3'b000) begin
          w_dec.code = C_SUB;
        end else if (w_f7 == 7'h20 && w_f3 == 3'b101) begin
          w_dec.code = C_SRA;
        end else begin
          w_ok = 1'b0;
        end
      end
      default: w_ok = 1'b0;
    endcase
    // Illegal entries carry only the PCs so dispatch can raise the trap.
    if (!w_ok) begin
      w_dec        = '0;
      w_dec.pc     = in_pc;
      w_dec.prd_pc = in_prd_pc;
      w_dec.ill    = 1'b1;
    end
  end

  assign w_full  = (r_count == LP_FULL);
  assign w_empty = (r_count == '0);

`ifdef DECODE_QUEUE_BYPASS_EN
  assign w_byp = w_empty & in_valid & out_ready & rdy & ~flush;
`else
  assign w_byp = 1'b0;
`endif

  assign in_ready  = ~w_full & ~flush;
  assign w_enq     = in_valid & in_ready & rdy & ~w_byp;
  assign w_deq     = ~w_empty & out_ready & rdy & ~flush;
  assign out_valid = ~w_empty | w_byp;
  assign count     = r_count;

  always_comb begin
    w_out = '0;
    if (w_byp) begin
      w_out = w_dec;
    end else if (!w_empty) begin
      w_out = r_mem[r_head];
    end
  end

  assign out_rd      = w_out.rd;
  assign out_rs1     = w_out.rs1;
  assign out_rs2     = w_out.rs2;
  assign out_imm     = w_out.imm;
  assign out_code    = w_out.code;
  assign out_type    = w_out.typ;
  assign out_pc      = w_out.pc;
  assign out_prd_pc  = w_out.prd_pc;
  assign out_illegal = w_out.ill;

  always_ff @(posedge clk) begin
    if (!rst && w_enq) begin
      r_mem[r_tail] <= w_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) r_tail <= r_tail + LP_PONE;
        if (w_deq) r_head <= r_head + LP_PONE;
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + LP_CONE;
          2'b01:   r_count <= r_count - LP_CONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: random and directed traffic against a mask/match
// RV32I reference model with a scoreboard queue and a dequeue monitor.
module tb_decode_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int NINS   = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_prd_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic [5:0]  out_code;
  logic [2:0]  out_type;
  logic [31:0] out_pc, out_prd_pc;
  logic        out_illegal;
  logic [ADDR_W:0] count;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [5:0]  code;
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [31:0] prd;
    logic        ill;
  } rec_t;

  rec_t sb[$];
  rec_t out_vec;

  assign out_vec = {out_rd, out_rs1, out_rs2, out_imm, out_code,
                    out_type, out_pc, out_prd_pc, out_illegal};

  // Format: 0 U, 1 J, 2 I, 3 B, 4 S, 5 shift-imm, 6 R.  Code = index+1.
  localparam logic [31:0] MATCH [NINS] = '{
    32'h37, 32'h17, 32'h6F, 32'h67,
    32'h63, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
    32'h3, 32'h1003, 32'h2003, 32'h4003, 32'h5003,
    32'h23, 32'h1023, 32'h2023,
    32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013,
    32'h1013, 32'h5013, 32'h40005013,
    32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
    32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033};
  localparam int FMT [NINS] = '{
    0, 0, 1, 2, 3, 3, 3, 3, 3, 3, 2, 2, 2, 2, 2, 4, 4, 4,
    2, 2, 2, 2, 2, 2, 5, 5, 5, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6};
  localparam int TYP [NINS] = '{
    1, 1, 5, 5, 4, 4, 4, 4, 4, 4, 2, 2, 2, 2, 2, 3, 3, 3,
    1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ROBBW(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_prd_pc(in_prd_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_code(out_code), .out_type(out_type),
    .out_pc(out_pc), .out_prd_pc(out_prd_pc),
    .out_illegal(out_illegal), .count(count));

  always #5 clk = ~clk;

  function automatic logic [31:0] mask_of(input int f);
    if (f <= 1) return 32'h0000007F;
    if (f >= 5) return 32'hFE00707F;
    return 32'h0000707F;
  endfunction

  function automatic rec_t model(input logic [31:0] i,
                                 input logic [31:0] pc,
                                 input logic [31:0] pp);
    rec_t r;
    logic signed [31:0] s;
    int hit;
    s = i;
    hit = -1;
    for (int n = 0; n < NINS; n++)
      if ((i & mask_of(FMT[n])) == MATCH[n]) hit = n;
    r = '0;
    r.pc = pc;
    r.prd = pp;
    if (hit < 0) begin
      r.ill = 1'b1;
      return r;
    end
    r.code = 6'(hit + 1);
    r.typ = 3'(TYP[hit]);
    case (FMT[hit])
      0: begin
        r.rd = i[11:7];
        r.imm = i & 32'hFFFFF000;
      end
      1: begin
        r.rd = i[11:7];
        r.imm = (i[31] ? 32'hFFF00000 : 32'h0) | (32'(i[19:12]) << 12)
              | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      2: begin
        r.rd = i[11:7];
        r.rs1 = i[19:15];
        r.imm = 32'(s >>> 20);
      end
      3: begin
        r.rs1 = i[19:15];
        r.rs2 = i[24:20];
        r.imm = (i[31] ? 32'hFFFFF000 : 32'h0) | (32'(i[7]) << 11)
              | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      end
      4: begin
        r.rs1 = i[19:15];
        r.rs2 = i[24:20];
        r.imm = (32'(s >>> 20) & ~32'h1F) | 32'(i[11:7]);
      end
      5: begin
        r.rd = i[11:7];
        r.rs1 = i[19:15];
        r.imm = 32'(i[24:20]);
      end
      default: begin
        r.rd = i[11:7];
        r.rs1 = i[19:15];
        r.rs2 = i[24:20];
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    int n;
    n = $urandom_range(0, NINS - 1);
    if ($urandom_range(0, 7) == 0) return $urandom;
    return MATCH[n] | ($urandom & ~mask_of(FMT[n]));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_rec(input string nm, input rec_t act, input rec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_head();
    if (sb.size() != 0) chk_rec("head", out_vec, sb[0]);
    else chk("head_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    rdy = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk_rec("rst_fields", out_vec, '0);
  endtask

  // One cycle of stimulus; expectations come from the scoreboard depth.
  task automatic cyc(input bit iv, input logic [31:0] inst,
                     input bit ordy, input bit r, input bit fl);
    bit er, ev, byp, enq;
    rec_t e;
    @(negedge clk);
    in_valid = iv;
    in_inst = inst;
    in_pc = $urandom;
    in_prd_pc = $urandom;
    out_ready = ordy;
    rdy = r;
    flush = fl;
    #1;
    byp = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && iv && ordy && r && !fl;
`endif
    er = (sb.size() != DEPTH) && !fl;
    ev = (sb.size() != 0) || byp;
    chk("count", 32'(count), sb.size());
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    enq = iv && er && r && !byp;
    e = model(inst, in_pc, in_prd_pc);
    @(posedge clk);
    #1;
    if (r && fl) sb.delete();
    else if (enq) sb.push_back(e);
  endtask

  always @(negedge clk) begin
    rec_t e;
    #2;
    if (!rst && rdy && !flush && out_ready) begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_rec("dequeue", out_vec, e);
      end
`ifdef DECODE_QUEUE_BYPASS_EN
      else if (in_valid) begin
        chk_rec("bypass", out_vec, model(in_inst, in_pc, in_prd_pc));
      end
`endif
    end
  end

  initial begin
    logic [31:0] held;
    do_reset();

    cyc(1, 32'h00500093, 0, 1, 0);
    check_head();
    chk("addi_code", 32'(out_code), 32'd19);
    chk("addi_type", 32'(out_type), 32'd1);
    chk("addi_rd", 32'(out_rd), 32'd1);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_count", 32'(count), 32'd1);

    do_reset();
    for (int k = 0; k < 9; k++) cyc(1, rand_inst(), 0, 1, 0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    held = rand_inst();
    cyc(1, held, 1, 1, 0);
    cyc(1, held, 0, 1, 0);
    chk("refill_count", 32'(count), 32'd8);
    for (int k = 0; k < 20; k++) cyc(1, rand_inst(), 1, 1, 0);
    chk("stream_count", 32'(count), 32'd7);

    do_reset();
    for (int k = 0; k < 5; k++) cyc(1, rand_inst(), 0, 1, 0);
    cyc(1, rand_inst(), 0, 1, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    cyc(1, 32'h00500093, 0, 1, 0);
    cyc(0, 32'h0, 1, 1, 0);

    do_reset();
    cyc(1, 32'hFFFFFFFF, 0, 1, 0);
    cyc(1, 32'h40005033, 0, 1, 0);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_code", 32'(out_code), 32'd0);
    check_head();
    cyc(0, 32'h0, 1, 1, 0);
    chk("sra_code", 32'(out_code), 32'd35);
    chk("sra_ill", 32'(out_illegal), 32'd0);
    check_head();

    do_reset();
    for (int k = 0; k < 3; k++) cyc(1, rand_inst(), 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, rand_inst(), 1, 0, 1);
      chk("frozen_count", 32'(count), 32'd3);
      check_head();
    end

`ifdef DECODE_QUEUE_BYPASS_EN
    do_reset();
    cyc(1, 32'h00500093, 1, 1, 0);
    chk("bypass_count", 32'(count), 32'd0);
`endif

    do_reset();
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 3) != 0, rand_inst(),
          $urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0,
          $urandom_range(0, 31) == 0);
    for (int k = 0; k < 12; k++) cyc(0, 32'h0, 1, 1, 0);
    chk("drain_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
